// File: rtl/decode_issue_controller.sv
// ---------------------------------------------------------------------------
// decode_issue_controller
//
// Decode/issue stage sitting between instruction fetch and execute. Fetched
// instructions land in a two-entry elastic buffer (output register plus a
// skid register) so fetch can keep streaming while execute back-pressures.
// Each instruction's immediate format is decoded as it is captured and is
// stored alongside it. The head instruction is issued to execute unless it
// would read the destination of a load still in execute (load-use bubble).
// A flush discards everything that is buffered.
//
// Optional feature macro: DECODE_PERF_CNT_EN
//   When defined, two 32-bit wrapping counters are added as outputs:
//   stall_cycles_o (cycles the head entry was held by a load-use hazard) and
//   flush_count_o (cycles with flush asserted).
//
// Parameters:
//   XLEN      - width of instruction and PC datapaths (at least 32)
//   RESET_PC  - PC presented on id_pc_o after reset, before the first issue
//
// Ports:
//   clk_i           rising-edge clock
//   reset_i         synchronous, active-high reset
//   if_valid_i      fetch presents an instruction
//   if_instr_i      fetched instruction
//   if_pc_i         PC of the fetched instruction
//   if_ready_o      stage accepts from fetch this cycle (registered)
//   ex_ready_i      execute accepts the issued instruction
//   ex_is_load_i    instruction currently in execute is a load
//   ex_rd_i         destination register of the instruction in execute
//   flush_i         redirect; discard all buffered instructions
//   id_valid_o      issued instruction valid (hazard-masked)
//   id_instr_o      issued instruction
//   id_pc_o         issued PC
//   id_imm_type_o   immediate format 0=none/R 1=I 2=S 3=B 4=U 5=J
//   id_rs1_o        instr[19:15]
//   id_rs2_o        instr[24:20]
//   id_rd_o         instr[11:7]
//   stall_cycles_o  (DECODE_PERF_CNT_EN only) hazard stall cycle count
//   flush_count_o   (DECODE_PERF_CNT_EN only) flush cycle count
// ---------------------------------------------------------------------------
module decode_issue_controller #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            if_valid_i,
  input  logic [XLEN-1:0] if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            if_ready_o,
  input  logic            ex_ready_i,
  input  logic            ex_is_load_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            flush_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [2:0]      id_imm_type_o,
  output logic [4:0]      id_rs1_o,
  output logic [4:0]      id_rs2_o,
  output logic [4:0]      id_rd_o
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cycles_o,
  output logic [31:0]     flush_count_o
`endif
);

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } immType_e;

  // Everything derived from the opcode that the stage needs to keep with an
  // entry: its immediate format and which source registers it really reads.
  typedef struct packed {
    immType_e immType;
    logic     usesRs1;
    logic     usesRs2;
  } decode_t;

  // Opcode classification. Unknown opcodes read no registers so that they
  // can never trigger a load-use bubble.
  function automatic decode_t decodeFormat(input logic [6:0] opcode);
    decode_t dec;
    dec = '{immType: IMM_NONE, usesRs1: 1'b0, usesRs2: 1'b0};
    unique case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111:
        dec = '{immType: IMM_I, usesRs1: 1'b1, usesRs2: 1'b0};
      7'b0100011:
        dec = '{immType: IMM_S, usesRs1: 1'b1, usesRs2: 1'b1};
      7'b1100011:
        dec = '{immType: IMM_B, usesRs1: 1'b1, usesRs2: 1'b1};
      7'b0110111, 7'b0010111:
        dec = '{immType: IMM_U, usesRs1: 1'b0, usesRs2: 1'b0};
      7'b1101111:
        dec = '{immType: IMM_J, usesRs1: 1'b0, usesRs2: 1'b0};
      7'b0110011:
        dec = '{immType: IMM_NONE, usesRs1: 1'b1, usesRs2: 1'b1};
      default:
        dec = '{immType: IMM_NONE, usesRs1: 1'b0, usesRs2: 1'b0};
    endcase
    return dec;
  endfunction

  state_e          state_q, state_d;
  logic            ifReady_q;
  logic [XLEN-1:0] outInstr_q, outInstr_d;
  logic [XLEN-1:0] outPc_q, outPc_d;
  decode_t         outDec_q, outDec_d;
  logic [XLEN-1:0] skidInstr_q, skidInstr_d;
  logic [XLEN-1:0] skidPc_q, skidPc_d;
  decode_t         skidDec_q, skidDec_d;

  logic    outValid;
  logic    hazard;
  logic    idValid;
  logic    accept;
  logic    issue;
  decode_t inDec;

  // The head instruction must wait if it reads a register that a load in
  // execute has not yet produced. x0 is never a real dependency. This only
  // masks id_valid; the entry itself stays put until the hazard clears.
  always_comb begin
    outValid = (state_q != EMPTY);
    hazard   = ex_is_load_i && (ex_rd_i != 5'd0) &&
               ((outDec_q.usesRs1 && (outInstr_q[19:15] == ex_rd_i)) ||
                (outDec_q.usesRs2 && (outInstr_q[24:20] == ex_rd_i)));
    idValid  = outValid && !hazard && !reset_i;
  end

  // Ready is registered so execute back-pressure never reaches fetch through
  // a combinational path; it is forced low only while reset is asserted.
  assign if_ready_o = ifReady_q && !reset_i;

  // Next-state logic for the elastic buffer. Entries always leave from the
  // output register, and the skid register only refills the output register,
  // which keeps the stream strictly in order. Flush overrides everything,
  // including an accept in the same cycle; an issue in that cycle has already
  // been seen by execute, so dropping the entry is the correct outcome.
  always_comb begin
    accept = if_valid_i && if_ready_o;
    issue  = idValid && ex_ready_i;
    inDec  = decodeFormat(if_instr_i[6:0]);

    state_d     = state_q;
    outInstr_d  = outInstr_q;
    outPc_d     = outPc_q;
    outDec_d    = outDec_q;
    skidInstr_d = skidInstr_q;
    skidPc_d    = skidPc_q;
    skidDec_d   = skidDec_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          outInstr_d = if_instr_i;
          outPc_d    = if_pc_i;
          outDec_d   = inDec;
        end
      end
      ONE: begin
        if (accept && issue) begin
          outInstr_d = if_instr_i;
          outPc_d    = if_pc_i;
          outDec_d   = inDec;
        end else if (accept) begin
          state_d     = TWO;
          skidInstr_d = if_instr_i;
          skidPc_d    = if_pc_i;
          skidDec_d   = inDec;
        end else if (issue) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (issue) begin
          state_d    = ONE;
          outInstr_d = skidInstr_q;
          outPc_d    = skidPc_q;
          outDec_d   = skidDec_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush_i) begin
      state_d     = EMPTY;
      outInstr_d  = outInstr_q;
      outPc_d     = outPc_q;
      outDec_d    = outDec_q;
      skidInstr_d = skidInstr_q;
      skidPc_d    = skidPc_q;
      skidDec_d   = skidDec_q;
    end
  end

  // State and datapath registers. Reset parks a NOP at RESET_PC in the output
  // register so the issue outputs are well defined before the first fetch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= EMPTY;
      ifReady_q   <= 1'b1;
      outInstr_q  <= NOP_INSTR;
      outPc_q     <= RESET_PC;
      outDec_q    <= '{immType: IMM_NONE, usesRs1: 1'b0, usesRs2: 1'b0};
      skidInstr_q <= '0;
      skidPc_q    <= '0;
      skidDec_q   <= '{immType: IMM_NONE, usesRs1: 1'b0, usesRs2: 1'b0};
    end else begin
      state_q     <= state_d;
      ifReady_q   <= (state_d != TWO);
      outInstr_q  <= outInstr_d;
      outPc_q     <= outPc_d;
      outDec_q    <= outDec_d;
      skidInstr_q <= skidInstr_d;
      skidPc_q    <= skidPc_d;
      skidDec_q   <= skidDec_d;
    end
  end

  // Issue outputs come straight from the output register; only id_valid
  // depends on the current execute-stage inputs.
  assign id_valid_o    = idValid;
  assign id_instr_o    = outInstr_q;
  assign id_pc_o       = outPc_q;
  assign id_imm_type_o = outDec_q.immType;
  assign id_rs1_o      = outInstr_q[19:15];
  assign id_rs2_o      = outInstr_q[24:20];
  assign id_rd_o       = outInstr_q[11:7];

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stallCycles_q;
  logic [31:0] flushCount_q;

  // Performance counters. Both wrap naturally at 32 bits. A stall cycle is
  // one where a valid head entry is held back by a load-use hazard.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stallCycles_q <= '0;
      flushCount_q  <= '0;
    end else begin
      if (outValid && hazard) begin
        stallCycles_q <= stallCycles_q + 32'd1;
      end
      if (flush_i) begin
        flushCount_q <= flushCount_q + 32'd1;
      end
    end
  end

  assign stall_cycles_o = stallCycles_q;
  assign flush_count_o  = flushCount_q;
`endif

endmodule

// File: tb/tb_decode_issue_controller.sv
module tb_decode_issue_controller;

  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        if_ready;
  logic        ex_ready = 1'b0;
  logic        ex_is_load = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        flush = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  id_imm_type;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: the stage is just an ordered queue of at most two
  // accepted instructions, plus the counters the optional feature exposes.
  logic [31:0] qInstr[$];
  logic [31:0] qPc[$];
  int unsigned stallExp = 0;
  int unsigned flushExp = 0;

  decode_issue_controller #(
    .XLEN(32),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .if_valid_i(if_valid),
    .if_instr_i(if_instr),
    .if_pc_i(if_pc),
    .if_ready_o(if_ready),
    .ex_ready_i(ex_ready),
    .ex_is_load_i(ex_is_load),
    .ex_rd_i(ex_rd),
    .flush_i(flush),
    .id_valid_o(id_valid),
    .id_instr_o(id_instr),
    .id_pc_o(id_pc),
    .id_imm_type_o(id_imm_type),
    .id_rs1_o(id_rs1),
    .id_rs2_o(id_rs2),
    .id_rd_o(id_rd)
`ifdef DECODE_PERF_CNT_EN
    ,
    .stall_cycles_o(stall_cycles),
    .flush_count_o(flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Safety net so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  // Immediate format straight from the opcode table.
  function automatic logic [2:0] refType(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    if (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111) return 3'd1;
    if (op == 7'b0100011) return 3'd2;
    if (op == 7'b1100011) return 3'd3;
    if (op == 7'b0110111 || op == 7'b0010111) return 3'd4;
    if (op == 7'b1101111) return 3'd5;
    return 3'd0;
  endfunction

  // Load-use rule: which formats read rs1/rs2, compared with the load's rd.
  function automatic logic refHazard(input logic [31:0] instr, input logic isLoad,
                                     input logic [4:0] rd);
    logic [6:0] op;
    logic r1, r2;
    op = instr[6:0];
    r1 = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011};
    r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    return isLoad && (rd != 5'd0) &&
           ((r1 && instr[19:15] == rd) || (r2 && instr[24:20] == rd));
  endfunction

  // Drives one cycle's inputs at the negative edge and lets outputs settle.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic exr, input logic ld, input logic [4:0] exrd,
                               input logic fl);
    if_valid   = v;
    if_instr   = instr;
    if_pc      = pc;
    ex_ready   = exr;
    ex_is_load = ld;
    ex_rd      = exrd;
    flush      = fl;
    #1;
  endtask

  // Advances one clock and updates the queue model with what should happen
  // at that edge, then returns at the following negative edge.
  task automatic tick();
    logic hz, expValid, accept, issue;
    hz       = (qInstr.size() > 0) ? refHazard(qInstr[0], ex_is_load, ex_rd) : 1'b0;
    expValid = (qInstr.size() > 0) && !hz && !reset;
    accept   = if_valid && (qInstr.size() < 2) && !reset;
    issue    = expValid && ex_ready;
    @(posedge clk);
    if (reset) begin
      qInstr.delete();
      qPc.delete();
      stallExp = 0;
      flushExp = 0;
    end else begin
      if ((qInstr.size() > 0) && hz) stallExp++;
      if (flush) begin
        flushExp++;
        qInstr.delete();
        qPc.delete();
      end else begin
        if (issue) begin
          void'(qInstr.pop_front());
          void'(qPc.pop_front());
        end
        if (accept) begin
          qInstr.push_back(if_instr);
          qPc.push_back(if_pc);
        end
      end
    end
    @(negedge clk);
  endtask

  // Reset values during and right after the reset cycle.
  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    total++; if (if_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_if_ready got=%b want=0", if_ready); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_id_valid got=%b want=0", id_valid); end
    total++; if (id_instr !== 32'h0000_0013) begin bad++; $display("[TB] FAIL reset_id_instr got=%h want=00000013", id_instr); end
    total++; if (id_pc !== RESET_PC) begin bad++; $display("[TB] FAIL reset_id_pc got=%h want=%h", id_pc, RESET_PC); end
    total++; if ({id_imm_type, id_rs1, id_rs2, id_rd} !== 18'd0) begin bad++; $display("[TB] FAIL reset_fields got=%h want=0", {id_imm_type, id_rs1, id_rs2, id_rd}); end
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    total++; if (if_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_if_ready got=%b want=1", if_ready); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_id_valid got=%b want=0", id_valid); end
  endtask

  // Single addi with execute ready: visible one cycle after accept.
  task automatic test_basic();
    applyStimulus(1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    total++; if (id_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid got=%b want=1", id_valid); end
    total++; if (id_imm_type !== 3'd1) begin bad++; $display("[TB] FAIL basic_type got=%0d want=1", id_imm_type); end
    total++; if (id_rd !== 5'd1) begin bad++; $display("[TB] FAIL basic_rd got=%0d want=1", id_rd); end
    total++; if (id_pc !== 32'h0) begin bad++; $display("[TB] FAIL basic_pc got=%h want=0", id_pc); end
    tick();
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_drained got=%b want=0", id_valid); end
  endtask

  // Fill both entries under back-pressure, then drain in order.
  task automatic test_skid();
    applyStimulus(1'b1, 32'h00208133, 32'h4, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00112023, 32'h8, 1'b0, 1'b0, 5'd0, 1'b0);
    total++; if (if_ready !== 1'b1) begin bad++; $display("[TB] FAIL skid_ready_one got=%b want=1", if_ready); end
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    total++; if (if_ready !== 1'b0) begin bad++; $display("[TB] FAIL skid_ready_full got=%b want=0", if_ready); end
    total++; if (id_instr !== 32'h00208133) begin bad++; $display("[TB] FAIL skid_head got=%h want=00208133", id_instr); end
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    total++; if (id_valid !== 1'b1 || id_instr !== 32'h00208133 || id_imm_type !== 3'd0) begin
      bad++; $display("[TB] FAIL skid_first got=%b/%h/%0d want=1/00208133/0", id_valid, id_instr, id_imm_type); end
    tick();
    total++; if (id_valid !== 1'b1 || id_instr !== 32'h00112023 || id_imm_type !== 3'd2 || id_pc !== 32'h8) begin
      bad++; $display("[TB] FAIL skid_second got=%b/%h/%0d/%h want=1/00112023/2/8", id_valid, id_instr, id_imm_type, id_pc); end
    total++; if (if_ready !== 1'b1) begin bad++; $display("[TB] FAIL skid_ready_back got=%b want=1", if_ready); end
    tick();
  endtask

  // Load-use stall holds the entry; x0 and non-reading formats never stall.
  task automatic test_hazard();
    applyStimulus(1'b1, 32'h00208133, 32'h10, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd2, 1'b0);
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL hazard_stall got=%b want=0", id_valid); end
    tick();
    total++; if (id_valid !== 1'b0 || id_instr !== 32'h00208133) begin
      bad++; $display("[TB] FAIL hazard_hold got=%b/%h want=0/00208133", id_valid, id_instr); end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd2, 1'b0);
    total++; if (id_valid !== 1'b1 || id_instr !== 32'h00208133) begin
      bad++; $display("[TB] FAIL hazard_release got=%b/%h want=1/00208133", id_valid, id_instr); end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd0, 1'b0);
    total++; if (id_valid !== 1'b1) begin bad++; $display("[TB] FAIL hazard_x0 got=%b want=1", id_valid); end
    tick();
    applyStimulus(1'b1, 32'h000000B7, 32'h14, 1'b1, 1'b1, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 1'b0);
    total++; if (id_valid !== 1'b1 || id_imm_type !== 3'd4) begin
      bad++; $display("[TB] FAIL hazard_lui got=%b/%0d want=1/4", id_valid, id_imm_type); end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
  endtask

  // Flush from the full state discards all entries and the same-cycle fetch.
  task automatic test_flush();
    applyStimulus(1'b1, 32'h00100093, 32'h20, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00200113, 32'h24, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00300193, 32'h28, 1'b0, 1'b0, 5'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    total++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL flush_empty got=%b/%b want=0/1", id_valid, if_ready); end
    tick();
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_nothing_issues got=%b want=0", id_valid); end
    applyStimulus(1'b1, 32'h00400213, 32'h2c, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    total++; if (id_valid !== 1'b1 || id_instr !== 32'h00400213 || id_pc !== 32'h2c) begin
      bad++; $display("[TB] FAIL flush_refill got=%b/%h/%h want=1/00400213/2c", id_valid, id_instr, id_pc); end
    tick();
  endtask

  // Immediate format per opcode, other instruction bits randomized.
  task automatic test_formats();
    logic [6:0] ops[7]   = '{7'b1100011, 7'b1101111, 7'b1100111, 7'b1111111, 7'b0010111, 7'b0000011, 7'b0110011};
    logic [2:0] types[7] = '{3'd3, 3'd5, 3'd1, 3'd0, 3'd4, 3'd1, 3'd0};
    for (int i = 0; i < 7; i++) begin
      logic [31:0] r;
      r = $urandom();
      applyStimulus(1'b1, {r[31:7], ops[i]}, 32'h100 + 32'(i * 4), 1'b1, 1'b0, 5'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
      total++; if (id_valid !== 1'b1 || id_imm_type !== types[i]) begin
        bad++; $display("[TB] FAIL format_%b got=%b/%0d want=1/%0d", ops[i], id_valid, id_imm_type, types[i]); end
      tick();
    end
  endtask

  // Reset asserted with an entry buffered drops it.
  task automatic test_mid_reset();
    applyStimulus(1'b1, 32'h00500093, 32'h40, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid got=%b want=0", id_valid); end
    tick();
    reset = 1'b0;
    #1;
    total++; if (id_valid !== 1'b0 || id_pc !== RESET_PC || id_instr !== 32'h13 || if_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL midreset_state got=%b/%h/%h/%b want=0/%h/00000013/1", id_valid, id_pc, id_instr, if_ready, RESET_PC); end
  endtask

  // Three hazard cycles and one flush straight after a reset.
  task automatic test_perf_counters();
    applyStimulus(1'b1, 32'h00208133, 32'h50, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd2, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL perf_flushed got=%b want=0", id_valid); end
`ifdef DECODE_PERF_CNT_EN
    total++; if (stall_cycles !== 32'd3) begin bad++; $display("[TB] FAIL perf_stall got=%0d want=3", stall_cycles); end
    total++; if (flush_count !== 32'd1) begin bad++; $display("[TB] FAIL perf_flush got=%0d want=1", flush_count); end
`endif
  endtask

  // Random traffic checked every cycle against the queue model.
  task automatic test_random();
    logic [6:0] ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111};
    logic [31:0] pc = 32'h2000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [31:0] r, instr;
      logic expValid;
      r = $urandom();
      instr = {r[31:25], 3'(r[2:0]) == 3'd0 ? 5'd0 : {3'b000, r[21:20]}, 3'b000, r[16:15],
               r[14:7], ops[$urandom_range(0, 9)]};
      applyStimulus(1'($urandom_range(0, 1)), instr, pc, ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
      expValid = (qInstr.size() > 0) && !refHazard(qInstr[0], ex_is_load, ex_rd);
      total++; if (id_valid !== expValid) begin bad++; $display("[TB] FAIL rand_valid cyc=%0d got=%b want=%b", cyc, id_valid, expValid); end
      total++; if (if_ready !== (qInstr.size() < 2)) begin bad++; $display("[TB] FAIL rand_ready cyc=%0d got=%b want=%b", cyc, if_ready, qInstr.size() < 2); end
      if (qInstr.size() > 0) begin
        total++;
        if (id_instr !== qInstr[0] || id_pc !== qPc[0] || id_imm_type !== refType(qInstr[0]) ||
            id_rs1 !== qInstr[0][19:15] || id_rs2 !== qInstr[0][24:20] || id_rd !== qInstr[0][11:7]) begin
          bad++;
          $display("[TB] FAIL rand_head cyc=%0d got=%h/%h/%0d want=%h/%h/%0d", cyc, id_instr, id_pc, id_imm_type,
                   qInstr[0], qPc[0], refType(qInstr[0]));
        end
      end
      if (if_valid && if_ready) pc = pc + 32'd4;
      tick();
    end
`ifdef DECODE_PERF_CNT_EN
    total++; if (stall_cycles !== stallExp) begin bad++; $display("[TB] FAIL rand_stall_cnt got=%0d want=%0d", stall_cycles, stallExp); end
    total++; if (flush_count !== flushExp) begin bad++; $display("[TB] FAIL rand_flush_cnt got=%0d want=%0d", flush_count, flushExp); end
`endif
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    test_reset();
    test_basic();
    test_skid();
    test_hazard();
    test_flush();
    test_formats();
    test_mid_reset();
    test_perf_counters();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
